// File: rtl/program_counter_stack.sv
// Program counter with a return-address stack, halt input and sticky stack-error flag.
// Optional breakpoint unit is compiled in when PC_BREAKPOINT_EN is defined.
module program_counter_stack #(
    parameter int ADDR_WIDTH  = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  countEnable,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  halt,
    input  logic                  outputEnable,
    input  logic [ADDR_WIDTH-1:0] jumpAddr,
`ifdef PC_BREAKPOINT_EN
    input  logic [ADDR_WIDTH-1:0] bpAddr,
    input  logic                  bpEnable,
    output logic                  bpHit,
`endif
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [SP_WIDTH-1:0]   stackLevel,
    output logic                  stackErr,
    output logic                  halted
);

    localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0] FULL_LEVEL = SP_WIDTH'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] stackMem [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] nextCount;
    logic [ADDR_WIDTH-1:0] incCount;
    logic [SP_WIDTH-1:0]   nextLevel;
    logic                  nextErr;
    logic                  doPush;
    logic                  freeze;
    logic [IDX_WIDTH-1:0]  pushIdx;
    logic [IDX_WIDTH-1:0]  popIdx;

    assign incCount = count + ADDR_WIDTH'(1);
    assign pushIdx  = IDX_WIDTH'(stackLevel);
    assign popIdx   = IDX_WIDTH'(stackLevel - SP_WIDTH'(1));

`ifdef PC_BREAKPOINT_EN
    // A taken breakpoint freezes the block exactly like halt until bpEnable drops.
    assign freeze = halt | (bpHit & bpEnable);
`else
    assign freeze = halt;
`endif

    always_comb begin
        nextCount = count;
        nextLevel = stackLevel;
        nextErr   = stackErr;
        doPush    = 1'b0;
        if (!freeze) begin
            if (call) begin
                if (stackLevel != FULL_LEVEL) begin
                    doPush    = 1'b1;
                    nextLevel = stackLevel + SP_WIDTH'(1);
                    nextCount = jumpAddr;
                end else begin
                    nextErr = 1'b1;
                end
            end else if (ret) begin
                if (stackLevel != '0) begin
                    nextCount = stackMem[popIdx];
                    nextLevel = stackLevel - SP_WIDTH'(1);
                end else begin
                    nextErr = 1'b1;
                end
            end else if (jump) begin
                nextCount = jumpAddr;
            end else if (countEnable) begin
                nextCount = incCount;
            end
        end
    end

    // addr samples count before this edge's update, giving one cycle of lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            addr       <= '0;
            stackLevel <= '0;
            stackErr   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            count      <= nextCount;
            stackLevel <= nextLevel;
            stackErr   <= nextErr;
            halted     <= halt;
            if (outputEnable) begin
                addr <= count;
            end
        end
    end

    // Stack contents need no reset; stackLevel alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && doPush) begin
            stackMem[pushIdx] <= incCount;
        end
    end

`ifdef PC_BREAKPOINT_EN
    always_ff @(posedge clk) begin
        if (reset || !bpEnable) begin
            bpHit <= 1'b0;
        end else if (!freeze && nextCount == bpAddr) begin
            bpHit <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the 4-bit program counter for the 8-bit CPU.
- Generalises address width and adds a return-address stack (call/ret), a halt input, and a sticky stack-error flag.
- Sits between the control sequencer (drives jump/call/ret/countEnable/halt) and the memory address register (consumes addr).

Parameters:
ADDR_WIDTH, 4, width of count, jumpAddr, addr and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
SP_WIDTH, $clog2(STACK_DEPTH+1), width of stackLevel output

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
countEnable  input  1  increment count this cycle
jump  input  1  load count from jumpAddr
call  input  1  push return address, load count from jumpAddr
ret  input  1  pop stack into count
halt  input  1  freeze count and stack
outputEnable  input  1  capture count into addr
jumpAddr  input  ADDR_WIDTH  target address for jump/call
addr  output  ADDR_WIDTH  registered address presented to MAR
count  output  ADDR_WIDTH  live internal counter value
stackLevel  output  SP_WIDTH  number of valid stack entries
stackErr  output  1  sticky overflow/underflow flag
halted  output  1  registered copy of halt

Behaviour:
- Reset (sync, active-high, highest priority):
  - count=0, addr=0, stackLevel=0, stackErr=0, halted=0.
  - Stack contents are don't-care.
  - Reset asserted mid-call/ret discards the operation.
- halted <= halt every cycle.
- If halt=1: count, stack and stackErr hold. addr still follows the outputEnable rule.
- Control priority per cycle (halt=0): call > ret > jump > countEnable. Only the highest asserted action takes effect; the rest are ignored.
- call:
  - If stackLevel<STACK_DEPTH: push (count+1) mod 2^ADDR_WIDTH, stackLevel+=1, count<=jumpAddr.
  - If full: no push, count holds, stackErr<=1.
- ret:
  - If stackLevel>0: count<=top entry, stackLevel-=1.
  - If empty: count holds, stackErr<=1.
- jump: count<=jumpAddr.
- countEnable: count<=(count+1) mod 2^ADDR_WIDTH. Wrap from all-ones to 0 is silent.
- outputEnable=1: addr<=count value before this edge's update (one-cycle latency vs count). outputEnable=0: addr holds.
- stackErr is cleared only by reset.
- Stack is LIFO. Push and pop never occur in the same cycle.
- Return address wraps: a call from address 2^ADDR_WIDTH-1 pushes 0.

Optional Feature:
- Macro: PC_BREAKPOINT_EN.
- Defined:
  - Adds input bpAddr[ADDR_WIDTH], input bpEnable, output bpHit.
  - When bpEnable=1 and the next count value equals bpAddr, count takes that value, bpHit<=1 (sticky), and the block self-halts from the following cycle as if halt=1.
  - Self-halt persists until reset or bpEnable=0; bpHit clears at the same time.
  - bpHit resets to 0.
- Undefined: ports absent, no breakpoint logic, behaviour otherwise identical.

Test Plan:
- Reset, then countEnable=1 and outputEnable=1 for 17 cycles (ADDR_WIDTH=4) -> count 0..15, 0; addr lags count by one cycle; no stackErr.
- count=5, call with jumpAddr=0xA -> count=0xA, stackLevel=1; then ret -> count=6, stackLevel=0.
- STACK_DEPTH=2: three nested calls from 1, 3, 7 -> third call ignored, count stays at second target, stackErr=1, stackLevel=2; two rets -> 4, then 2.
- ret with empty stack at count=3 -> count=3, stackErr=1; later jump to 9 works; stackErr stays 1 until reset.
- call+ret+jump+countEnable asserted together at count=2, jumpAddr=0xC -> call wins: count=0xC, stack top=3. Then halt=1 with countEnable=1 for 3 cycles -> count holds at 0xC, halted=1.
- PC_BREAKPOINT_EN defined, bpAddr=4, bpEnable=1, counting from 0 -> count reaches 4, bpHit=1, count holds at 4; deassert bpEnable -> counting resumes at 5.
